kws_mac_sequencer: RTL

Command-driven sequencer for the 4-lane int8 SIMD multiply-accumulate datapath in the KWS accelerator CFU. The CPU pre-loads packed input and filter words into two local operand FIFOs. A single RUN command then streams N word pairs through the MAC, one pair per cycle, and returns the 32-bit accumulator. Each inner-loop word pair therefore no longer costs one CFU round trip. The block sits directly on the CPU's CFU cmd/rsp port.

---
 rtl/kws_mac_pkg.sv | 51 +++++
 rtl/kws_operand_fifo.sv | 70 +++++++
 rtl/kws_mac_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/kws_mac_pkg.sv
// Shared types and the 4-lane int8 SIMD MAC arithmetic for the KWS CFU sequencer.
package kws_mac_pkg;

  typedef enum logic [2:0] {
    OP_PUSH_IN  = 3'd0,
    OP_PUSH_FLT = 3'd1,
    OP_RUN      = 3'd2,
    OP_CLR_ACC  = 3'd3,
    OP_FLUSH    = 3'd4,
    OP_SET_OFS  = 3'd5,
    OP_READ_ACC = 3'd6,
    OP_ILLEGAL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int OFS_W  = 9;
  localparam int SUM_W  = OFS_W + 1;
  localparam int PROD_W = 18;
  localparam int ACC_W  = 32;

  // Offset-corrected input byte times signed filter byte, summed over four lanes.
  function automatic logic signed [ACC_W-1:0] simd_mac4(
    input logic [31:0]              a,
    input logic [31:0]              f,
    input logic signed [OFS_W-1:0]  offset
  );
    logic signed [ACC_W-1:0]  sum;
    logic signed [SUM_W-1:0]  x;
    logic signed [PROD_W-1:0] xe;
    logic signed [PROD_W-1:0] fe;
    logic signed [PROD_W-1:0] prod;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      x    = {{(SUM_W-LANE_W){a[LANE_W*i+LANE_W-1]}}, a[LANE_W*i +: LANE_W]}
           + {offset[OFS_W-1], offset};
      xe   = {{(PROD_W-SUM_W){x[SUM_W-1]}}, x};
      fe   = {{(PROD_W-LANE_W){f[LANE_W*i+LANE_W-1]}}, f[LANE_W*i +: LANE_W]};
      prod = xe * fe;
      sum  = sum + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
    return sum;
  endfunction

endpackage

// File: rtl/kws_operand_fifo.sv
// 32-bit operand FIFO with push/pop/flush and an occupancy count of 0..DEPTH.
module kws_operand_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [31:0]            push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [31:0]            pop_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o     = (count_q == FullCount);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && (count_q != '0);
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_d + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = count_d - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/kws_mac_sequencer.sv
// CFU command sequencer: buffers operand words locally and streams RUN bursts
// through the SIMD MAC, one word pair per cycle.
module kws_mac_sequencer
  import kws_mac_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int RESET_OFFSET = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_payload_response_ok,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] DepthWord = 32'(FIFO_DEPTH);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [8:0]  ofs_q, ofs_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_ok_q, rsp_ok_d;

  logic          in_push, flt_push, pop_pair, flush_all;
  logic [31:0]   in_data, flt_data;
  logic [CW-1:0] in_count, flt_count;
  logic          in_full, flt_full;
  logic [8:0]    run_n, min_avail;
  logic          run_overrun;
  logic [31:0]   acc_step;
  op_e           op;
  logic          unused_bits;

  assign unused_bits = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1,
                         cmd_payload_inputs_0[31:9]};

  kws_operand_fifo #(.DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (in_push),
    .push_data_i (cmd_payload_inputs_0),
    .pop_i       (pop_pair),
    .flush_i     (flush_all),
    .pop_data_o  (in_data),
    .count_o     (in_count),
    .full_o      (in_full)
  );

  kws_operand_fifo #(.DEPTH(FIFO_DEPTH)) u_flt_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (flt_push),
    .push_data_i (cmd_payload_inputs_0),
    .pop_i       (pop_pair),
    .flush_i     (flush_all),
    .pop_data_o  (flt_data),
    .count_o     (flt_count),
    .full_o      (flt_full)
  );

  assign op          = op_e'(cmd_payload_function_id[2:0]);
  assign run_n       = {1'b0, cmd_payload_inputs_0[7:0]};
  assign min_avail   = (in_count < flt_count) ? 9'(in_count) : 9'(flt_count);
  assign run_overrun = run_n > min_avail;
  assign acc_step    = acc_q + simd_mac4(in_data, flt_data, ofs_q);

  assign rsp_payload_outputs_0   = rsp_data_q;
  assign rsp_payload_response_ok = rsp_ok_q;

  // Every command except a non-empty legal RUN completes in its accept cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ofs_d      = ofs_q;
    rsp_data_d = rsp_data_q;
    rsp_ok_d   = rsp_ok_q;
    in_push    = 1'b0;
    flt_push   = 1'b0;
    pop_pair   = 1'b0;
    flush_all  = 1'b0;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d    = ST_RESP;
          rsp_ok_d   = 1'b1;
          rsp_data_d = '0;
          case (op)
            OP_PUSH_IN: begin
              if (in_full) begin
                rsp_ok_d   = 1'b0;
                rsp_data_d = DepthWord;
              end else begin
                in_push    = 1'b1;
                rsp_data_d = 32'(in_count) + 32'd1;
              end
            end
            OP_PUSH_FLT: begin
              if (flt_full) begin
                rsp_ok_d   = 1'b0;
                rsp_data_d = DepthWord;
              end else begin
                flt_push   = 1'b1;
                rsp_data_d = 32'(flt_count) + 32'd1;
              end
            end
            OP_RUN: begin
              rsp_data_d = acc_q;
              if (run_overrun) begin
                rsp_ok_d = 1'b0;
              end else if (run_n != 9'd0) begin
                cnt_d   = run_n[7:0];
                state_d = ST_EXEC;
              end
            end
            OP_CLR_ACC: acc_d = '0;
            OP_FLUSH: begin
              flush_all = 1'b1;
              acc_d     = '0;
            end
            OP_SET_OFS:  ofs_d = cmd_payload_inputs_0[8:0];
            OP_READ_ACC: rsp_data_d = acc_q;
            default:     rsp_ok_d = 1'b0;
          endcase
        end
      end
      ST_EXEC: begin
        pop_pair = 1'b1;
        acc_d    = acc_step;
        cnt_d    = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d    = ST_RESP;
          rsp_data_d = acc_step;
          rsp_ok_d   = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      ofs_q      <= 9'(RESET_OFFSET);
      rsp_data_q <= '0;
      rsp_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ofs_q      <= ofs_d;
      rsp_data_q <= rsp_data_d;
      rsp_ok_q   <= rsp_ok_d;
    end
  end

endmodule
